// File: rtl/addsub_seq_chunked.sv
// Multi-cycle add/subtract for the Y86-64 execute stage: CHUNK bits per clock, carry held
// between slices, Y86 condition codes (OF/ZF/SF) plus CF latched together with the result.
module addsub_seq_chunked #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             of,
   output logic             cf,
   output logic             zf,
   output logic             sf
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   // Handshake: a transfer happens on any rising edge where valid && ready are both high.
   // in_ready is high only in IDLE; out_valid is high only in DONE and holds until taken.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             op_q, op_d;
   logic             zacc_q, zacc_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             of_q, of_d;
   logic             cf_q, cf_d;
   logic             zf_q, zf_d;
   logic             sf_q, sf_d;

   int unsigned      sl_base;
   logic [CHUNK-1:0] a_sl, b_sl, sum_sl;
   logic             cout_sl;
   logic             cin_msb;

   // One slice of the ripple: operands already hold b' (b or ~b), carry seeds the +1 for subtract.
   always_comb begin
      sl_base = int'(cnt_q) * CHUNK;
      a_sl    = a_q[sl_base +: CHUNK];
      b_sl    = b_q[sl_base +: CHUNK];
      {cout_sl, sum_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
      cin_msb = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ sum_sl[CHUNK-1];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      op_d     = op_q;
      zacc_d   = zacc_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      of_d     = of_q;
      cf_d     = cf_q;
      zf_d     = zf_q;
      sf_d     = sf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = op ? ~b : b;
               op_d    = op;
               carry_d = op;
               cnt_d   = '0;
               zacc_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d[sl_base +: CHUNK] = sum_sl;
            carry_d = cout_sl;
            zacc_d  = zacc_q & (sum_sl == '0);
            if (cnt_q == LAST) begin
               // Result is copied out only on completion so the visible value never tears.
               result_d = acc_d;
               of_d     = cin_msb ^ cout_sl;
               cf_d     = op_q ? ~cout_sl : cout_sl;
               zf_d     = zacc_q & (sum_sl == '0);
               sf_d     = sum_sl[CHUNK-1];
               cnt_d    = '0;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         op_q     <= 1'b0;
         zacc_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         of_q     <= 1'b0;
         cf_q     <= 1'b0;
         zf_q     <= 1'b0;
         sf_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         op_q     <= op_d;
         zacc_q   <= zacc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         of_q     <= of_d;
         cf_q     <= cf_d;
         zf_q     <= zf_d;
         sf_q     <= sf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign of        = of_q;
   assign cf        = cf_q;
   assign zf        = zf_q;
   assign sf        = sf_q;

endmodule

// File: tb/tb_addsub_seq_chunked.sv
// Bench for addsub_seq_chunked: three builds (CHUNK 16/64/8) against an arithmetic reference
// model with a per-cycle output check, plus directed cases with literal expectations.
module tb_addsub_seq_chunked;

   localparam int W  = 64;
   localparam int NI = 3;

   typedef struct packed {
      logic [W-1:0] res;
      logic         of_f;
      logic         cf_f;
      logic         zf_f;
      logic         sf_f;
   } rsp_t;

   logic         clk;
   logic         rst;
   logic         in_valid_v  [NI];
   logic         in_ready_v  [NI];
   logic         op_v        [NI];
   logic [W-1:0] a_v         [NI];
   logic [W-1:0] b_v         [NI];
   logic         out_valid_v [NI];
   logic         out_ready_v [NI];
   logic [W-1:0] result_v    [NI];
   logic         of_v        [NI];
   logic         cf_v        [NI];
   logic         zf_v        [NI];
   logic         sf_v        [NI];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference model state
   rsp_t exp_q  [NI][$];
   rsp_t m_last [NI];
   bit   m_busy [NI];
   bit   m_done [NI];
   int   m_due  [NI];

   addsub_seq_chunked #(.WIDTH(W), .CHUNK(16)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .op(op_v[0]),
      .a(a_v[0]), .b(b_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
      .result(result_v[0]), .of(of_v[0]), .cf(cf_v[0]), .zf(zf_v[0]), .sf(sf_v[0]));

   addsub_seq_chunked #(.WIDTH(W), .CHUNK(64)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .op(op_v[1]),
      .a(a_v[1]), .b(b_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
      .result(result_v[1]), .of(of_v[1]), .cf(cf_v[1]), .zf(zf_v[1]), .sf(sf_v[1]));

   addsub_seq_chunked #(.WIDTH(W), .CHUNK(8)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .op(op_v[2]),
      .a(a_v[2]), .b(b_v[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
      .result(result_v[2]), .of(of_v[2]), .cf(cf_v[2]), .zf(zf_v[2]), .sf(sf_v[2]));

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int n_of(int i);
      case (i)
         0:       return 4;
         1:       return 1;
         default: return 8;
      endcase
   endfunction

   // Plain two's-complement arithmetic; flags from sign/magnitude rules.
   function automatic rsp_t ref_calc(logic op, logic [W-1:0] a, logic [W-1:0] b);
      rsp_t r;
      logic [W:0] wide;
      if (!op) begin
         wide   = {1'b0, a} + {1'b0, b};
         r.res  = wide[W-1:0];
         r.cf_f = wide[W];
         r.of_f = (a[W-1] == b[W-1]) && (r.res[W-1] != a[W-1]);
      end else begin
         r.res  = a - b;
         r.cf_f = (a < b);
         r.of_f = (a[W-1] != b[W-1]) && (r.res[W-1] != a[W-1]);
      end
      r.zf_f = (r.res == '0);
      r.sf_f = r.res[W-1];
      return r;
   endfunction

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 64'h8000_0000_0000_0000;
         3:       return 64'h7FFF_FFFF_FFFF_FFFF;
         4:       return W'($urandom_range(0, 3));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic check(string name, int inst, logic [W-1:0] got, logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s inst%0d cyc=%0d got=%h exp=%h", name, inst, cyc, got, exp);
      end
   endtask

   // Model advance at a rising edge, using the inputs the bench holds across that edge.
   task automatic model_step();
      cyc++;
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            m_busy[i] = 0;
            m_done[i] = 0;
            exp_q[i].delete();
            m_last[i] = '0;
         end else if (m_done[i] && out_ready_v[i]) begin
            m_busy[i] = 0;
            m_done[i] = 0;
         end else if (!m_busy[i] && in_valid_v[i]) begin
            m_busy[i] = 1;
            m_due[i]  = cyc + n_of(i);
            exp_q[i].push_back(ref_calc(op_v[i], a_v[i], b_v[i]));
         end else if (m_busy[i] && !m_done[i] && cyc == m_due[i]) begin
            m_done[i] = 1;
            m_last[i] = exp_q[i].pop_front();
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < NI; i++) begin
         check("out_valid", i, W'(out_valid_v[i]), W'(m_done[i]));
         check("in_ready",  i, W'(in_ready_v[i]),  W'(!m_busy[i]));
         check("result",    i, result_v[i],        m_last[i].res);
         check("of",        i, W'(of_v[i]),        W'(m_last[i].of_f));
         check("cf",        i, W'(cf_v[i]),        W'(m_last[i].cf_f));
         check("zf",        i, W'(zf_v[i]),        W'(m_last[i].zf_f));
         check("sf",        i, W'(sf_v[i]),        W'(m_last[i].sf_f));
      end
   endtask

   // One clock: model at the rising edge, outputs compared at the falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic send(int i, logic op, logic [W-1:0] a, logic [W-1:0] b);
      bit ok = 0;
      in_valid_v[i] = 1'b1;
      op_v[i] = op;
      a_v[i]  = a;
      b_v[i]  = b;
      for (int k = 0; k < 50 && !ok; k++) begin
         if (in_ready_v[i]) ok = 1;
         tick();
      end
      check("send_accept", i, W'(ok), W'(1));
      in_valid_v[i] = 1'b0;
      op_v[i] = 1'($urandom);
      a_v[i]  = {$urandom, $urandom};
      b_v[i]  = {$urandom, $urandom};
   endtask

   // lat counts cycles from the handshake cycle to the first cycle out_valid is high.
   task automatic wait_valid(int i, output int lat);
      lat = 1;
      while (!out_valid_v[i] && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic take(int i, int hold, bit toggle);
      for (int k = 0; k < hold; k++) begin
         if (toggle) begin
            in_valid_v[i] = 1'($urandom);
            op_v[i] = 1'($urandom);
            a_v[i]  = {$urandom, $urandom};
            b_v[i]  = {$urandom, $urandom};
         end
         tick();
      end
      in_valid_v[i]  = 1'b0;
      out_ready_v[i] = 1'b1;
      tick();
      out_ready_v[i] = 1'b0;
   endtask

   task automatic expect_lit(int i, logic [W-1:0] res, logic o, logic c, logic z, logic s);
      check("lit_result", i, result_v[i], res);
      check("lit_of", i, W'(of_v[i]), W'(o));
      check("lit_cf", i, W'(cf_v[i]), W'(c));
      check("lit_zf", i, W'(zf_v[i]), W'(z));
      check("lit_sf", i, W'(sf_v[i]), W'(s));
   endtask

   initial begin
      int lat;
      rsp_t r;
      logic op;
      logic [W-1:0] a;
      logic [W-1:0] b;

      // reset
      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         in_valid_v[i]  = 1'b0;
         out_ready_v[i] = 1'b0;
         op_v[i] = 1'b0;
         a_v[i]  = '0;
         b_v[i]  = '0;
      end
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_in_ready", 0, W'(in_ready_v[0]), W'(1));
      check("rst_out_valid", 0, W'(out_valid_v[0]), W'(0));
      expect_lit(0, '0, 0, 0, 0, 0);

      // model pins
      r = ref_calc(1'b1, 64'd0, 64'd1);
      check("model_sub_res", 0, r.res, 64'hFFFF_FFFF_FFFF_FFFF);
      check("model_sub_cf", 0, W'(r.cf_f), W'(1));
      r = ref_calc(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      check("model_add_of", 0, W'(r.of_f), W'(1));

      // 5 + 7
      send(0, 1'b0, 64'd5, 64'd7);
      wait_valid(0, lat);
      check("lat_c16", 0, W'(lat), W'(5));
      expect_lit(0, 64'd12, 0, 0, 0, 0);
      take(0, 0, 0);

      // signed overflow on add
      send(0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      wait_valid(0, lat);
      expect_lit(0, 64'h8000_0000_0000_0000, 1, 0, 0, 1);
      take(0, 1, 0);

      // zero result, then borrow
      send(0, 1'b1, 64'd3, 64'd3);
      wait_valid(0, lat);
      expect_lit(0, 64'd0, 0, 0, 1, 0);
      take(0, 0, 0);
      send(0, 1'b1, 64'd0, 64'd1);
      wait_valid(0, lat);
      expect_lit(0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 1);
      take(0, 0, 0);

      // subtract overflow, consumer stalls 10 cycles with inputs toggling
      send(0, 1'b1, 64'h8000_0000_0000_0000, 64'd1);
      wait_valid(0, lat);
      expect_lit(0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 0, 0);
      out_ready_v[0] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         in_valid_v[0] = 1'($urandom);
         a_v[0] = {$urandom, $urandom};
         b_v[0] = {$urandom, $urandom};
         tick();
      end
      check("hold_valid", 0, W'(out_valid_v[0]), W'(1));
      check("hold_ready", 0, W'(in_ready_v[0]), W'(0));
      expect_lit(0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 0, 0);
      take(0, 0, 0);

      // reset during slice 2
      send(0, 1'b0, 64'd1, 64'd1);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_valid", 0, W'(out_valid_v[0]), W'(0));
      check("mid_rst_ready", 0, W'(in_ready_v[0]), W'(1));
      expect_lit(0, '0, 0, 0, 0, 0);
      repeat (6) tick();
      check("mid_rst_no_pulse", 0, W'(out_valid_v[0]), W'(0));
      send(0, 1'b0, 64'd1, 64'd1);
      wait_valid(0, lat);
      check("lat_after_rst", 0, W'(lat), W'(5));
      expect_lit(0, 64'd2, 0, 0, 0, 0);
      take(0, 0, 0);

      // latency of the other builds
      send(1, 1'b0, 64'd5, 64'd7);
      wait_valid(1, lat);
      check("lat_c64", 1, W'(lat), W'(2));
      expect_lit(1, 64'd12, 0, 0, 0, 0);
      take(1, 0, 0);
      send(2, 1'b1, 64'd3, 64'd3);
      wait_valid(2, lat);
      check("lat_c8", 2, W'(lat), W'(9));
      expect_lit(2, 64'd0, 0, 0, 1, 0);
      take(2, 0, 0);

      // random traffic on each build
      for (int i = 0; i < NI; i++) begin
         int nops;
         nops = (i == 0) ? 300 : 2000;
         for (int k = 0; k < nops; k++) begin
            op = 1'($urandom);
            a  = rnd_operand();
            b  = rnd_operand();
            repeat ($urandom_range(0, 2)) tick();
            send(i, op, a, b);
            wait_valid(i, lat);
            check("rand_lat", i, W'(lat), W'(n_of(i) + 1));
            take(i, $urandom_range(0, 3), 1'b1);
         end
      end

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
